somador_multiciclo: RTL and testbench
=====================================

// Module: somador_multiciclo
// PURPOSE
//  Parametrised multi-cycle ripple add/sub unit, next generation of the 4-bit adder in the ULA.
//  Operands are WIDTH bits wide; CHUNK bits are summed per clock through a ripple chain.
//  A persistent carry flag allows chaining of wide words (ADC/SBB).
//  Valid/ready handshake on input and output; sits between the ULA operand regs and result mux.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
//  CHUNK  4  bits processed per cycle; WIDTH % CHUNK must be 0, else elaboration error
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      unit can accept (high only in IDLE)
//  op         in   2      00 ADD, 01 SUB, 10 ADC, 11 SBB
//  a          in   WIDTH  operand A (unsigned/two's complement)
//  b          in   WIDTH  operand B
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (SUB/SBB: 1 = no borrow)
//  ovf        out  1      signed overflow
//  zero       out  1      sum == 0
//  neg        out  1      sum[WIDTH-1]
//  carry_flag out  1      stored carry used by ADC/SBB
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; sum=0; cout=ovf=zero=neg=0; carry_flag=0.
//  - FSM IDLE -> RUN on in_valid&&in_ready: latch a, b_eff, cin; chunk index k=0.
//    b_eff = b (ADD/ADC) or ~b (SUB/SBB); cin = 0 ADD, 1 SUB, carry_flag ADC/SBB.
//  - RUN: each edge computes sum[k*CHUNK +: CHUNK] = a_chunk + b_eff_chunk + c; c <= chunk carry.
//    k increments; on last chunk (k = WIDTH/CHUNK-1) go DONE, out_valid<=1.
//  - Latency: out_valid rises exactly WIDTH/CHUNK edges after the accepting edge.
//  - DONE: sum/flags stable while out_valid&&!out_ready; on out_ready go IDLE, out_valid<=0.
//    Flags remain readable after handshake (not cleared) until the next op completes.
//  - carry_flag <= cout on entry to DONE only; unchanged otherwise.
//  - ovf = carry into MSB XOR carry out of MSB (both from MSB chunk of the chain).
//  - in_valid ignored while not IDLE (in_ready=0); op/a/b sampled only at accept.
//  - Throughput: one op per WIDTH/CHUNK + 2 cycles (accept, RUN, DONE handshake, IDLE).
//  - CHUNK = WIDTH: single RUN cycle, latency 1.
//  - rst in any state, incl. mid-RUN: abort, all outputs and carry_flag to reset values next edge.
//  - rst has priority over simultaneous in_valid/out_ready.
// TESTING (WIDTH=8, CHUNK=4 unless noted)
//  1 ADD a=0x7F b=0x01 -> sum=0x80 cout=0 ovf=1 neg=1 zero=0; out_valid 2 edges after accept.
//  2 SUB a=0x05 b=0x05 -> sum=0x00 zero=1 cout=1 ovf=0; SUB 0x00-0x01 -> 0xFF cout=0 neg=1.
//  3 Chain: ADD 0xFF+0x01 -> 0x00 cout=1 carry_flag=1; then ADC 0x00+0x00 -> 0x01 cout=0 carry_flag=0.
//  4 Backpressure: out_ready=0 for 5 cycles -> sum/flags/out_valid stable, in_ready=0, pulsed in_valid ignored.
//  5 rst mid-RUN after ADD 0xFF+0x01 accepted -> next edge in_ready=1 out_valid=0 carry_flag=0; ADC 1+1 -> 0x02.
//  6 Sweep (8,1) latency 8, (16,16) latency 1, (16,4) latency 4: 1000 random ops vs golden model, all flags.

Source files
------------

// File: rtl/somador_multiciclo.sv
// Multi-cycle ripple add/sub: CHUNK bits per clock, persistent carry flag for ADC/SBB chaining.
// Valid/ready handshake on both sides; result and flags held until the next op completes.
module somador_multiciclo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             carry_flag
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned KW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [KW-1:0] LastK   = KW'(NumChunks - 1);

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("somador_multiciclo: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d, cf_q, cf_d;

  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] chunk_ext;
  logic             msb_cin;

  // Operands are shifted right each cycle so the active chunk always sits at bit 0.
  always_comb begin
    a_c       = a_q[CHUNK-1:0];
    b_c       = b_q[CHUNK-1:0];
    chunk_res = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, c_q};
    msb_cin   = chunk_res[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    chunk_ext = '0;
    chunk_ext[CHUNK-1:0] = chunk_res[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    k_d     = k_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    cf_d    = cf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op[0] ? ~b : b;
          c_d     = op[1] ? cf_q : op[0];
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = chunk_res[CHUNK];
        acc_d = (acc_q >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
        k_d   = k_q + KW'(1);
        if (k_q == LastK) begin
          state_d = StDone;
          sum_d   = acc_d;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = msb_cin ^ chunk_res[CHUNK];
          zero_d  = (acc_d == '0);
          neg_d   = acc_d[WIDTH-1];
          cf_d    = chunk_res[CHUNK];
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      cf_q    <= cf_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign sum        = sum_q;
  assign cout       = cout_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;
  assign neg        = neg_q;
  assign carry_flag = cf_q;

endmodule

// File: tb/tb_somador_multiciclo.sv
// Bench for somador_multiciclo: directed cases on an 8/4 instance, random sweep on 8/1, 16/16, 16/4.
// Expected results come from a reference model and flow through a scoreboard queue.
module tb_somador_multiciclo;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Main 8/4 instance
  logic       iv, ir, ov, ordy, cout, ovf, zero, neg, cf;
  logic [1:0] op;
  logic [7:0] a, b, sum;

  // Sweep instances: 0 = (8,1), 1 = (16,16), 2 = (16,4)
  logic [2:0]  s_iv, s_ir, s_ov, s_ordy, s_cout, s_ovf, s_zero, s_neg, s_cf;
  logic [1:0]  s_op;
  logic [15:0] s_a, s_b, s1_sum, s2_sum;
  logic [7:0]  s0_sum;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  logic cf_m;
  logic cf_s[3];

  somador_multiciclo #(.WIDTH(8), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .op(op), .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .neg(neg), .carry_flag(cf)
  );

  somador_multiciclo #(.WIDTH(8), .CHUNK(1)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(s_iv[0]), .in_ready(s_ir[0]), .op(s_op), .a(s_a[7:0]),
    .b(s_b[7:0]), .out_valid(s_ov[0]), .out_ready(s_ordy[0]), .sum(s0_sum), .cout(s_cout[0]),
    .ovf(s_ovf[0]), .zero(s_zero[0]), .neg(s_neg[0]), .carry_flag(s_cf[0])
  );

  somador_multiciclo #(.WIDTH(16), .CHUNK(16)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(s_iv[1]), .in_ready(s_ir[1]), .op(s_op), .a(s_a),
    .b(s_b), .out_valid(s_ov[1]), .out_ready(s_ordy[1]), .sum(s1_sum), .cout(s_cout[1]),
    .ovf(s_ovf[1]), .zero(s_zero[1]), .neg(s_neg[1]), .carry_flag(s_cf[1])
  );

  somador_multiciclo #(.WIDTH(16), .CHUNK(4)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(s_iv[2]), .in_ready(s_ir[2]), .op(s_op), .a(s_a),
    .b(s_b), .out_valid(s_ov[2]), .out_ready(s_ordy[2]), .sum(s2_sum), .cout(s_cout[2]),
    .ovf(s_ovf[2]), .zero(s_zero[2]), .neg(s_neg[2]), .carry_flag(s_cf[2])
  );

  // Whole-word reference: signed overflow from operand/result signs.
  function automatic res_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input int w);
    logic [16:0] mask, av, bv, full;
    res_t r;
    mask   = (17'd1 << w) - 17'd1;
    av     = {1'b0, x} & mask;
    bv     = (o[0] ? ~{1'b0, y} : {1'b0, y}) & mask;
    full   = av + bv + {16'd0, (o[1] ? c : o[0])};
    r.sum  = full[15:0] & mask[15:0];
    r.cout = full[w];
    r.neg  = full[w-1];
    r.zero = (r.sum == 16'd0);
    r.ovf  = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
    return r;
  endfunction

  function automatic res_t main_res();
    return {8'h00, sum, cout, ovf, zero, neg};
  endfunction

  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    res_t e;
    @(negedge clk);
    iv = 1'b1; op = o; a = x; b = y;
    e = model(o, {8'h00, x}, {8'h00, y}, cf_m, 8);
    q.push_back(e);
    cf_m = e.cout;
    @(posedge clk); #1;
    iv = 1'b0; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk); ordy = 1'b1;
    @(posedge clk); #1; ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = 1'b0; ordy = 1'b0; op = '0; a = '0; b = '0;
    s_iv = '0; s_ordy = '0; s_op = '0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ir, ov, sum, cout, ovf, zero, neg, cf} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
      errors++;
      $display("FAIL reset_main: got %b want %b", {ir, ov, sum, cout, ovf, zero, neg, cf},
               {1'b1, 1'b0, 8'h00, 5'b0});
    end
    checks++;
    if ({s_ir, s_ov, s_cf} !== {3'b111, 3'b000, 3'b000}) begin
      errors++;
      $display("FAIL reset_sweep: got %b want %b", {s_ir, s_ov, s_cf}, 9'b111000000);
    end
    @(negedge clk); rst = 1'b0;
    cf_m = 1'b0;
  endtask

  task automatic test_add_ovf();
    int lat;
    res_t e;
    issue(2'b00, 8'h7F, 8'h01);
    wait_out(lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL add_latency: got %0d want 2", lat);
    end
    e = q.pop_front();
    checks++;
    if (main_res() !== e) begin
      errors++; $display("FAIL add_result: got %h want %h", main_res(), e);
    end
    checks++;
    if ({sum, cout, ovf, zero, neg} !== {8'h80, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_7f_01: got %h want %h", {sum, cout, ovf, zero, neg}, 12'h805);
    end
    handshake();
  endtask

  task automatic test_sub();
    int lat;
    res_t e;
    issue(2'b01, 8'h05, 8'h05);
    wait_out(lat);
    e = q.pop_front();
    checks++;
    if (main_res() !== e || zero !== 1'b1 || cout !== 1'b1) begin
      errors++; $display("FAIL sub_equal: got %h want %h", main_res(), e);
    end
    handshake();
    issue(2'b01, 8'h00, 8'h01);
    wait_out(lat);
    e = q.pop_front();
    checks++;
    if (main_res() !== e || sum !== 8'hFF || neg !== 1'b1 || cout !== 1'b0) begin
      errors++; $display("FAIL sub_borrow: got %h want %h", main_res(), e);
    end
    handshake();
  endtask

  task automatic test_chain();
    int lat;
    res_t e;
    issue(2'b00, 8'hFF, 8'h01);
    wait_out(lat);
    e = q.pop_front();
    checks++;
    if (main_res() !== e) begin
      errors++; $display("FAIL chain_add: got %h want %h", main_res(), e);
    end
    checks++;
    if (cf !== 1'b1) begin
      errors++; $display("FAIL chain_flag_set: got %b want 1", cf);
    end
    handshake();
    issue(2'b10, 8'h00, 8'h00);
    wait_out(lat);
    e = q.pop_front();
    checks++;
    if (main_res() !== e || sum !== 8'h01) begin
      errors++; $display("FAIL chain_adc: got %h want %h", main_res(), e);
    end
    checks++;
    if (cf !== 1'b0) begin
      errors++; $display("FAIL chain_flag_clr: got %b want 0", cf);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    res_t e;
    issue(2'b01, 8'h12, 8'h34);
    wait_out(lat);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv = 1'b1; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({ov, ir} !== 2'b10 || main_res() !== e) begin
        errors++;
        $display("FAIL backpressure_hold: got %b/%h want 10/%h", {ov, ir}, main_res(), e);
      end
    end
    iv = 1'b0;
    handshake();
    checks++;
    if ({ov, ir, cf} !== 3'b010) begin
      errors++; $display("FAIL backpressure_release: got %b want 010", {ov, ir, cf});
    end
    checks++;
    if (main_res() !== e) begin
      errors++; $display("FAIL flags_retained: got %h want %h", main_res(), e);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    res_t e;
    issue(2'b00, 8'hFF, 8'h01);
    wait_out(lat);
    e = q.pop_front();
    handshake();
    issue(2'b00, 8'hFF, 8'h01);
    @(negedge clk);
    rst = 1'b1; iv = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ir, ov, cf, sum, cout, ovf, zero, neg} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'b0}) begin
      errors++;
      $display("FAIL reset_mid_run: got %b want %b", {ir, ov, cf, sum, cout, ovf, zero, neg},
               {3'b100, 12'h000});
    end
    @(negedge clk);
    rst = 1'b0; iv = 1'b0; ordy = 1'b0;
    q.delete();
    cf_m = 1'b0;
    issue(2'b10, 8'h01, 8'h01);
    wait_out(lat);
    e = q.pop_front();
    checks++;
    if (lat !== 2 || main_res() !== e || sum !== 8'h02) begin
      errors++; $display("FAIL adc_after_reset: got %h lat %0d want %h lat 2", main_res(), lat, e);
    end
    handshake();
  endtask

  task automatic test_sweep();
    int   lat, w, lexp;
    res_t e, act;
    logic acf;
    for (int s = 0; s < 3; s++) begin
      w    = (s == 0) ? 8 : 16;
      lexp = (s == 0) ? 8 : ((s == 1) ? 1 : 4);
      cf_s[s] = 1'b0;
      for (int n = 0; n < 334; n++) begin
        @(negedge clk);
        s_iv[s] = 1'b1; s_op = 2'($urandom); s_a = 16'($urandom); s_b = 16'($urandom);
        e = model(s_op, s_a, s_b, cf_s[s], w);
        q.push_back(e);
        cf_s[s] = e.cout;
        @(posedge clk); #1;
        s_iv[s] = 1'b0; s_op = 2'($urandom); s_a = 16'($urandom); s_b = 16'($urandom);
        lat = 0;
        while (!s_ov[s] && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        checks++;
        if (lat !== lexp) begin
          errors++; $display("FAIL sweep%0d_latency: got %0d want %0d", s, lat, lexp);
        end
        e = q.pop_front();
        case (s)
          0:       act = {8'h00, s0_sum, s_cout[0], s_ovf[0], s_zero[0], s_neg[0]};
          1:       act = {s1_sum, s_cout[1], s_ovf[1], s_zero[1], s_neg[1]};
          default: act = {s2_sum, s_cout[2], s_ovf[2], s_zero[2], s_neg[2]};
        endcase
        acf = s_cf[s];
        checks++;
        if (act !== e || acf !== e.cout) begin
          errors++;
          $display("FAIL sweep%0d_result op %0d: got %h cf %b want %h cf %b", s, n, act, acf,
                   e, e.cout);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk); s_ordy[s] = 1'b1;
        @(posedge clk); #1; s_ordy[s] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub();
    test_chain();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
